// File: rtl/operand_forward_ctrl_if.sv
// Decode-side bundle for operand_forward_ctrl: ID instruction fields in, selector codes and stall out.
// stall_count is only present when STALL_CNT_EN is defined.
interface operand_forward_ctrl_if #(
  parameter int unsigned REG_ADDR = 4
`ifdef STALL_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
);
  logic                hold;
  logic                flush;
  logic                id_valid;
  logic [REG_ADDR-1:0] id_rs1;
  logic [REG_ADDR-1:0] id_rs2;
  logic                id_rs1_used;
  logic                id_rs2_used;
  logic                id_use_imm;
  logic [REG_ADDR-1:0] id_rd;
  logic                id_rd_we;
  logic                id_is_load;
  logic [1:0]          ex_sel_a;
  logic [1:0]          ex_sel_b;
  logic                stall;
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0]    stall_count;

  modport master (
    output hold, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_use_imm, id_rd, id_rd_we, id_is_load,
    input  ex_sel_a, ex_sel_b, stall, stall_count
  );
  modport slave (
    input  hold, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_use_imm, id_rd, id_rd_we, id_is_load,
    output ex_sel_a, ex_sel_b, stall, stall_count
  );
`else
  modport master (
    output hold, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_use_imm, id_rd, id_rd_we, id_is_load,
    input  ex_sel_a, ex_sel_b, stall
  );
  modport slave (
    input  hold, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_use_imm, id_rd, id_rd_we, id_is_load,
    output ex_sel_a, ex_sel_b, stall
  );
`endif
endinterface

// File: rtl/operand_forward_ctrl.sv
// EX-stage operand forwarding selector generation with load-use stall detection.
// Optional saturating stall counter enabled by defining STALL_CNT_EN.
module operand_forward_ctrl #(
  parameter int unsigned REG_ADDR = 4
`ifdef STALL_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input logic                  clk,
  input logic                  rst_n,
  operand_forward_ctrl_if.slave bus
);

  logic [REG_ADDR-1:0] ex_rd, mem_rd;
  logic                ex_we, ex_ld, mem_we;
  logic                a_ex, a_mem, b_ex, b_mem, b_reg;
  logic                stall_c, kill;
  logic [1:0]          sel_a_n, sel_b_n;
  logic [1:0]          sel_a_q, sel_b_q;

  function automatic logic hit(input logic [REG_ADDR-1:0] rs, input logic used,
                               input logic [REG_ADDR-1:0] rd, input logic we);
    return used && we && (rs != '0) && (rd == rs);
  endfunction

  always_comb begin
    b_reg   = bus.id_rs2_used & ~bus.id_use_imm;
    a_ex    = hit(bus.id_rs1, bus.id_rs1_used, ex_rd, ex_we);
    a_mem   = hit(bus.id_rs1, bus.id_rs1_used, mem_rd, mem_we);
    b_ex    = hit(bus.id_rs2, b_reg, ex_rd, ex_we);
    b_mem   = hit(bus.id_rs2, b_reg, mem_rd, mem_we);
    stall_c = bus.id_valid & ~bus.flush & ex_ld & (a_ex | b_ex);
    // Any of these turns the ID slot into a bubble entering EX
    kill    = bus.flush | stall_c | ~bus.id_valid;

    sel_a_n = 2'b00;
    sel_b_n = 2'b00;
    if (!kill) begin
      if (a_ex)       sel_a_n = 2'b01;
      else if (a_mem) sel_a_n = 2'b10;

      if (bus.id_use_imm) sel_b_n = 2'b11;
      else if (b_ex)      sel_b_n = 2'b01;
      else if (b_mem)     sel_b_n = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd   <= '0;
      ex_we   <= 1'b0;
      ex_ld   <= 1'b0;
      mem_rd  <= '0;
      mem_we  <= 1'b0;
      sel_a_q <= 2'b00;
      sel_b_q <= 2'b00;
    end else if (!bus.hold) begin
      mem_rd  <= ex_rd;
      mem_we  <= ex_we;
      sel_a_q <= sel_a_n;
      sel_b_q <= sel_b_n;
      if (kill) begin
        ex_rd <= '0;
        ex_we <= 1'b0;
        ex_ld <= 1'b0;
      end else begin
        ex_rd <= bus.id_rd;
        ex_we <= bus.id_rd_we;
        ex_ld <= bus.id_is_load;
      end
    end
  end

  assign bus.ex_sel_a = sel_a_q;
  assign bus.ex_sel_b = sel_b_q;
  assign bus.stall    = stall_c;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                cnt_q <= '0;
    else if (!bus.hold && stall_c && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.stall_count = cnt_q;
`endif

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Directed bench for operand_forward_ctrl: expected selector codes queued per ID step, checked after the edge.
module tb_operand_forward_ctrl;
  localparam int unsigned REG_ADDR = 4;
`ifdef STALL_CNT_EN
  localparam int unsigned CNT_W = 8;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [3:0] sb[$];

  always #5 clk = ~clk;

`ifdef STALL_CNT_EN
  operand_forward_ctrl_if #(.REG_ADDR(REG_ADDR), .CNT_W(CNT_W)) bus ();
  operand_forward_ctrl #(.REG_ADDR(REG_ADDR), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`else
  operand_forward_ctrl_if #(.REG_ADDR(REG_ADDR)) bus ();
  operand_forward_ctrl #(.REG_ADDR(REG_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input int rs1, input int rs2, input logic u1,
                     input logic u2, input logic imm, input int rd, input logic we,
                     input logic ld, input logic fl, input logic hd);
    bus.id_valid    = v;
    bus.id_rs1      = REG_ADDR'(rs1);
    bus.id_rs2      = REG_ADDR'(rs2);
    bus.id_rs1_used = u1;
    bus.id_rs2_used = u2;
    bus.id_use_imm  = imm;
    bus.id_rd       = REG_ADDR'(rd);
    bus.id_rd_we    = we;
    bus.id_is_load  = ld;
    bus.flush       = fl;
    bus.hold        = hd;
  endtask

  // One ID cycle: stall checked mid-cycle, registered selectors checked after the edge
  task automatic cyc(input string tag, input logic es, input logic [1:0] ea, input logic [1:0] eb);
    logic [3:0] e;
    sb.push_back({ea, eb});
    @(negedge clk);
    chk({tag, "/stall"}, 32'(bus.stall), 32'(es));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "/sel_a"}, 32'(bus.ex_sel_a), 32'(e[3:2]));
    chk({tag, "/sel_b"}, 32'(bus.ex_sel_b), 32'(e[1:0]));
  endtask

  initial begin
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst/sel_a", 32'(bus.ex_sel_a), 0);
    chk("rst/sel_b", 32'(bus.ex_sel_b), 0);
    chk("rst/stall", 32'(bus.stall), 0);
`ifdef STALL_CNT_EN
    chk("rst/count", 32'(bus.stall_count), 0);
`endif
    rst_n = 1'b1;

    // ADD r3,r1,r2 ; ADD r4,r3,r3
    drv(1, 1, 2, 1, 1, 0, 3, 1, 0, 0, 0); cyc("add_r3", 0, 2'b00, 2'b00);
    drv(1, 3, 3, 1, 1, 0, 4, 1, 0, 0, 0); cyc("fwd_ex", 0, 2'b01, 2'b01);

    // ADD r5,r1,r1 ; NOP ; SUB r6,r5,r1
    drv(1, 1, 1, 1, 1, 0, 5, 1, 0, 0, 0); cyc("add_r5", 0, 2'b00, 2'b00);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("nop",    0, 2'b00, 2'b00);
    drv(1, 5, 1, 1, 1, 0, 6, 1, 0, 0, 0); cyc("fwd_mem", 0, 2'b10, 2'b00);

    // LW r2,(r1) ; ADD r7,r2,r1 -> one stall then MEM forward
    drv(1, 1, 0, 1, 0, 0, 2, 1, 1, 0, 0); cyc("lw_r2",   0, 2'b00, 2'b00);
    drv(1, 2, 1, 1, 1, 0, 7, 1, 0, 0, 0); cyc("lu_stall", 1, 2'b00, 2'b00);
    cyc("lu_after", 0, 2'b10, 2'b00);
`ifdef STALL_CNT_EN
    chk("lu/count", 32'(bus.stall_count), 1);
`endif

    // r0 never forwarded ; immediate overrides operand B
    drv(1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0); cyc("add_r0",  0, 2'b00, 2'b00);
    drv(1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0); cyc("use_r0",  0, 2'b00, 2'b00);
    drv(1, 2, 2, 1, 1, 0, 3, 1, 0, 0, 0); cyc("add_r3b", 0, 2'b00, 2'b00);
    drv(1, 3, 3, 1, 1, 1, 8, 1, 0, 0, 0); cyc("addi",    0, 2'b01, 2'b11);

    // LW r2 then consumer with flush -> no stall, bubble
    drv(1, 0, 0, 1, 0, 0, 2, 1, 1, 0, 0); cyc("lw_r2b",  0, 2'b00, 2'b00);
    drv(1, 2, 2, 1, 1, 0, 9, 1, 0, 1, 0); cyc("flush",   0, 2'b00, 2'b00);
    drv(1, 2, 1, 1, 1, 0, 10, 1, 0, 0, 0); cyc("post_fl", 0, 2'b10, 2'b00);

    // hold freezes selectors and tracking slots
    drv(1, 10, 10, 1, 1, 0, 11, 1, 0, 0, 1);
    cyc("hold1", 0, 2'b10, 2'b00);
    cyc("hold2", 0, 2'b10, 2'b00);
    cyc("hold3", 0, 2'b10, 2'b00);
    drv(1, 10, 10, 1, 1, 0, 11, 1, 0, 0, 0); cyc("unhold", 0, 2'b01, 2'b01);

    // reset asserted in the middle of a load-use stall
    drv(1, 11, 0, 1, 0, 0, 5, 1, 1, 0, 0); cyc("lw_r5", 0, 2'b01, 2'b00);
    drv(1, 5, 0, 1, 1, 0, 12, 1, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst/stall", 32'(bus.stall), 1);
    chk("pre_rst/sel_a", 32'(bus.ex_sel_a), 32'(2'b01));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst/stall", 32'(bus.stall), 0);
    chk("mid_rst/sel_a", 32'(bus.ex_sel_a), 0);
    chk("mid_rst/sel_b", 32'(bus.ex_sel_b), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
`ifdef STALL_CNT_EN
    chk("mid_rst/count", 32'(bus.stall_count), 0);
`endif
    cyc("rel1", 0, 2'b00, 2'b00);
    cyc("rel2", 0, 2'b00, 2'b00);

`ifdef STALL_CNT_EN
    // LW r2,(r2) repeatedly: a stall every other cycle, counter must saturate
    drv(1, 2, 0, 1, 0, 0, 2, 1, 1, 0, 0);
    repeat (600) @(posedge clk);
    #1;
    chk("sat/count", 32'(bus.stall_count), 32'((1 << CNT_W) - 1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/operand_forward_ctrl.md
Name: operand_forward_ctrl

Overview:
- Generates the registered 2-bit selector codes that drive the two EX-stage operand 4:1 muxes, operand A and operand B.
- Mux data inputs:
  - d0 = register-file read
  - d1 = EX/MEM ALU result
  - d2 = MEM/WB write-back value
  - d3 = immediate (operand B only)
- Tracks destination registers of in-flight instructions (EX, MEM) and detects load-use hazards.
- Sits between decode and the ID/EX register.

Parameters:
- REG_ADDR, 4, register-address width (2**REG_ADDR architectural registers; register 0 hardwired zero)
- CNT_W, 16, width of stall_count (optional feature only)

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- hold  input  1  global pipeline freeze (memory wait); no internal state changes while high
- flush  input  1  kill instructions in ID and EX (branch taken)
- id_valid  input  1  instruction in ID is real
- id_rs1  input  REG_ADDR  source register A
- id_rs2  input  REG_ADDR  source register B
- id_rs1_used  input  1  operand A reads a register
- id_rs2_used  input  1  operand B reads a register
- id_use_imm  input  1  operand B is the immediate
- id_rd  input  REG_ADDR  destination register
- id_rd_we  input  1  instruction writes id_rd
- id_is_load  input  1  instruction is a load
- ex_sel_a  output  2  registered selector for operand-A mux (00/01/10 only)
- ex_sel_b  output  2  registered selector for operand-B mux
- stall  output  1  combinational; hold PC/IF/ID, insert bubble into EX
- stall_count  output  CNT_W  only with STALL_CNT_EN

Behaviour:
- Reset (rst_n low, asynchronous):
  - ex_sel_a = ex_sel_b = 2'b00
  - EX and MEM tracking slots cleared (we=0, load=0, rd=0)
  - stall_count = 0
- Tracking slots: EX slot {rd, we, load}; MEM slot {rd, we}.
- Each edge with hold=0: MEM slot <= EX slot; EX slot <= ID instruction, or a bubble on stall/flush/!id_valid. A bubble has we=0, load=0.
- Register match rule: rs != 0, rs_used=1, slot we=1, slot rd == rs.
- Selector rule, computed in ID and registered into ex_sel_* (1-cycle latency), first match wins:
  - EX-slot match -> 01
  - else MEM-slot match -> 10
  - else 00 (register file provides write-before-read, so WB-stage producers need no forwarding)
- Operand B: id_use_imm=1 -> 11, overrides any match.
- Load-use: stall = id_valid & !flush & EX slot load=1 & EX-slot match on rs1 or rs2 (used, non-zero, non-immediate operand B).
  - Stall lasts exactly 1 cycle.
  - On the next cycle the load sits in MEM and the consumer gets 10.
- While stall=1 (hold=0): ex_sel_a/b <= 00 and EX slot <= bubble.
- flush=1 (hold=0):
  - ex_sel_a/b <= 00, EX slot <= bubble, stall forced 0.
  - MEM slot still takes the old EX slot; an instruction already in EX is not killed by this block.
- hold=1: ex_sel_*, slots and stall_count keep their values. stall is still evaluated combinationally; upstream uses hold | stall.
- id_valid=0: ex_sel_a/b <= 00, EX slot <= bubble, stall=0.
- Simultaneous flush and stall condition: flush wins, no stall.
- Reset asserted mid-stall: outputs return to reset values immediately; no stall after release until a new load enters EX.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined:
  - stall_count increments on each edge where stall=1 and hold=0.
  - Saturates at 2**CNT_W-1, no wrap.
  - Cleared by reset.
- Undefined: stall_count port and counter absent; no other behaviour changes.

Test Plan:
- ADD r3 then ADD r4,r3,r3 back-to-back -> cycle after second instruction's ID, ex_sel_a=01 and ex_sel_b=01; stall never 1.
- ADD r5, NOP, SUB r6,r5,r1 -> SUB gets ex_sel_a=10, ex_sel_b=00.
- LW r2 then ADD r7,r2,r1 -> stall=1 for exactly one cycle; bubble sels=00; then ex_sel_a=10. With STALL_CNT_EN, stall_count=1.
- ADD r0,... then ADD r1,r0,r0 -> sels 00 (no forwarding from r0). ADDI using r3 with id_use_imm=1 after writer of r3 -> ex_sel_b=11.
- LW r2 followed by consumer with flush=1 in the same cycle -> stall=0, ex_sel_*=00. Then hold=1 for 3 cycles -> all outputs frozen.
- Assert rst_n=0 during stall -> ex_sel_*=00 and stall=0 immediately. With STALL_CNT_EN, force 65536 stalls -> stall_count holds 16'hFFFF.
